// File: rtl/stolen_cdc_pkg.sv
// Purpose: shared constants, parameter limits and helpers for the stolen_cdc event synchronizer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package stolen_cdc_pkg;

    // Legal parameter ranges, checked at elaboration by the top module.
    localparam int WIDTH_MIN   = 1;
    localparam int WIDTH_MAX   = 64;
    localparam int SYNC_FF_MIN = 2;
    localparam int SYNC_FF_MAX = 10;
    localparam int FILTER_MIN  = 1;
    localparam int FILTER_MAX  = 65535;

    // Tag carried by every synchronizer flop so CDC tooling can find the chains.
    localparam string STOLEN_CDC_ATTR = "EVENT_SYNC";

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

    // Width of the per-channel stability counter (always at least one bit).
    function automatic int filter_cnt_width(input int filter_cycles);
        int w;
        w = clog2(filter_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/stolen_cdc_filter_bit.sv
// Purpose: one asynchronous channel -- synchronizer chain, stability filter, edge pulses (optional glitch flag under STOLEN_CDC_GLITCH_FLAG_EN).
// Latency: DEST_SYNC_FF + FILTER_CYCLES - 1 edges after the first edge sampling a stable new input.
// Backpressure: none; pulses are single-cycle and cannot be stalled.
module stolen_cdc_filter_bit
    import stolen_cdc_pkg::*;
#(
    parameter int   DEST_SYNC_FF  = 4,
    parameter int   FILTER_CYCLES = 4,
    parameter logic INIT_BIT      = 1'b0
) (
    input  logic dest_clk,
    input  logic dest_rst,
    input  logic src_in,
`ifdef STOLEN_CDC_GLITCH_FLAG_EN
    input  logic glitch_clr,
    output logic glitch_flag,
`endif
    output logic dest_level,
    output logic dest_rise,
    output logic dest_fall
);

    localparam int CNT_W = filter_cnt_width(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE", STOLEN_CDC = "EVENT_SYNC" *)
    logic [DEST_SYNC_FF-1:0] sync_stages;

    logic             sync_out;
    logic [CNT_W-1:0] cnt;
    logic             differs;
    logic             accept;
    logic             glitch_seen;

    // Shift the raw asynchronous input through the metastability chain.
    always_ff @(posedge dest_clk) begin
        if (dest_rst) begin
            sync_stages <= {DEST_SYNC_FF{INIT_BIT}};
        end else begin
            sync_stages <= {sync_stages[DEST_SYNC_FF-2:0], src_in};
        end
    end

    assign sync_out = sync_stages[DEST_SYNC_FF-1];

    // Classify the current cycle: new value pending, accepted, or a pending value that collapsed.
    always_comb begin
        differs     = 1'b0;
        accept      = 1'b0;
        glitch_seen = 1'b0;
        differs     = (sync_out != dest_level);
        accept      = differs && (cnt == CNT_LAST);
        glitch_seen = !differs && (cnt != '0);
    end

    // Count consecutive differing cycles; commit the new level once it has been stable long enough.
    always_ff @(posedge dest_clk) begin
        if (dest_rst) begin
            cnt        <= '0;
            dest_level <= INIT_BIT;
            dest_rise  <= 1'b0;
            dest_fall  <= 1'b0;
        end else begin
            dest_rise <= 1'b0;
            dest_fall <= 1'b0;
            if (!differs) begin
                cnt <= '0;
            end else if (accept) begin
                cnt        <= '0;
                dest_level <= sync_out;
                dest_rise  <= sync_out;
                dest_fall  <= ~sync_out;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef STOLEN_CDC_GLITCH_FLAG_EN
    // Sticky record of a rejected excursion; a new glitch beats a same-cycle clear.
    always_ff @(posedge dest_clk) begin
        if (dest_rst) begin
            glitch_flag <= 1'b0;
        end else begin
            glitch_flag <= glitch_seen | (glitch_flag & ~glitch_clr);
        end
    end
`else
    // Glitch classification is only consumed when the flag is built.
    logic glitch_unused;
    assign glitch_unused = glitch_seen;
`endif

endmodule

// File: rtl/stolen_cdc_event_sync.sv
// Purpose: WIDTH independent async-level synchronizers with glitch filter and rise/fall pulses (glitch flag ports under STOLEN_CDC_GLITCH_FLAG_EN).
// Latency: DEST_SYNC_FF + FILTER_CYCLES - 1 dest_clk edges from first sampling edge to dest_level/pulse.
// Backpressure: none; every channel runs free and pulses last exactly one cycle.
(* KEEP_HIERARCHY = "TRUE" *)
module stolen_cdc_event_sync
    import stolen_cdc_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter int               DEST_SYNC_FF  = 4,
    parameter int               FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] INIT_VAL      = '0
) (
    input  logic             dest_clk,
    input  logic             dest_rst,
    input  logic [WIDTH-1:0] src_in,
`ifdef STOLEN_CDC_GLITCH_FLAG_EN
    input  logic [WIDTH-1:0] glitch_clr,
    output logic [WIDTH-1:0] glitch_flag,
`endif
    output logic [WIDTH-1:0] dest_level,
    output logic [WIDTH-1:0] dest_rise,
    output logic [WIDTH-1:0] dest_fall
);

    // Reject out-of-range configurations before anything is built.
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("stolen_cdc_event_sync: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end
    if (DEST_SYNC_FF < SYNC_FF_MIN || DEST_SYNC_FF > SYNC_FF_MAX) begin : g_bad_sync
        $error("stolen_cdc_event_sync: DEST_SYNC_FF %0d outside %0d..%0d",
               DEST_SYNC_FF, SYNC_FF_MIN, SYNC_FF_MAX);
    end
    if (FILTER_CYCLES < FILTER_MIN || FILTER_CYCLES > FILTER_MAX) begin : g_bad_filter
        $error("stolen_cdc_event_sync: FILTER_CYCLES %0d outside %0d..%0d",
               FILTER_CYCLES, FILTER_MIN, FILTER_MAX);
    end

    // One fully independent filter per channel.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        stolen_cdc_filter_bit #(
            .DEST_SYNC_FF  (DEST_SYNC_FF),
            .FILTER_CYCLES (FILTER_CYCLES),
            .INIT_BIT      (INIT_VAL[i])
        ) u_filter (
            .dest_clk    (dest_clk),
            .dest_rst    (dest_rst),
            .src_in      (src_in[i]),
`ifdef STOLEN_CDC_GLITCH_FLAG_EN
            .glitch_clr  (glitch_clr[i]),
            .glitch_flag (glitch_flag[i]),
`endif
            .dest_level  (dest_level[i]),
            .dest_rise   (dest_rise[i]),
            .dest_fall   (dest_fall[i])
        );
    end

endmodule

// File: tb/tb_stolen_cdc_event_sync.sv
// Purpose: directed self-checking bench for stolen_cdc_event_sync (default, INIT_VAL=0xFF and fast-filter builds).
// Latency: expectations hand-computed from DEST_SYNC_FF + FILTER_CYCLES - 1.
// Backpressure: n/a.
module tb_stolen_cdc_event_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default build: WIDTH=8, DEST_SYNC_FF=4, FILTER_CYCLES=4, INIT_VAL=0.
    logic       rst_m;
    logic [7:0] src_m;
    logic [7:0] level_m, rise_m, fall_m;
    // INIT_VAL=0xFF build.
    logic       rst_i;
    logic [7:0] src_i;
    logic [7:0] level_i, rise_i, fall_i;
    // Fast build: WIDTH=1, DEST_SYNC_FF=2, FILTER_CYCLES=1.
    logic       rst_f;
    logic [0:0] src_f;
    logic [0:0] level_f, rise_f, fall_f;

`ifdef STOLEN_CDC_GLITCH_FLAG_EN
    logic [7:0] gclr_m, gflag_m;
    logic [7:0] gclr_i, gflag_i;
    logic [0:0] gclr_f, gflag_f;
`endif

    stolen_cdc_event_sync #(
        .WIDTH(8), .DEST_SYNC_FF(4), .FILTER_CYCLES(4), .INIT_VAL(8'h00)
    ) dut (
        .dest_clk(clk), .dest_rst(rst_m), .src_in(src_m),
`ifdef STOLEN_CDC_GLITCH_FLAG_EN
        .glitch_clr(gclr_m), .glitch_flag(gflag_m),
`endif
        .dest_level(level_m), .dest_rise(rise_m), .dest_fall(fall_m)
    );

    stolen_cdc_event_sync #(
        .WIDTH(8), .DEST_SYNC_FF(4), .FILTER_CYCLES(4), .INIT_VAL(8'hFF)
    ) dut_init (
        .dest_clk(clk), .dest_rst(rst_i), .src_in(src_i),
`ifdef STOLEN_CDC_GLITCH_FLAG_EN
        .glitch_clr(gclr_i), .glitch_flag(gflag_i),
`endif
        .dest_level(level_i), .dest_rise(rise_i), .dest_fall(fall_i)
    );

    stolen_cdc_event_sync #(
        .WIDTH(1), .DEST_SYNC_FF(2), .FILTER_CYCLES(1), .INIT_VAL(1'b0)
    ) dut_fast (
        .dest_clk(clk), .dest_rst(rst_f), .src_in(src_f),
`ifdef STOLEN_CDC_GLITCH_FLAG_EN
        .glitch_clr(gclr_f), .glitch_flag(gflag_f),
`endif
        .dest_level(level_f), .dest_rise(rise_f), .dest_fall(fall_f)
    );

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (level_m !== 8'h00) begin errors++; $display("FAIL reset_level_m got %h want 00", level_m); end
        checks++;
        if ((rise_m | fall_m) !== 8'h00) begin errors++; $display("FAIL reset_pulses_m got %h/%h want 00/00", rise_m, fall_m); end
        checks++;
        if (level_i !== 8'hFF) begin errors++; $display("FAIL reset_level_i got %h want ff", level_i); end
        checks++;
        if (level_f !== 1'b0) begin errors++; $display("FAIL reset_level_f got %b want 0", level_f); end
`ifdef STOLEN_CDC_GLITCH_FLAG_EN
        checks++;
        if (gflag_m !== 8'h00) begin errors++; $display("FAIL reset_gflag got %h want 00", gflag_m); end
`endif
    endtask

    task automatic test_single_rise();
        src_m = 8'h01;
        step(7);
        checks++;
        if (level_m !== 8'h00 || rise_m !== 8'h00) begin errors++; $display("FAIL rise_early got %h/%h want 00/00", level_m, rise_m); end
        step(1);
        checks++;
        if (level_m !== 8'h01 || rise_m !== 8'h01) begin errors++; $display("FAIL rise_edge got %h/%h want 01/01", level_m, rise_m); end
        step(1);
        checks++;
        if (level_m !== 8'h01 || rise_m !== 8'h00) begin errors++; $display("FAIL rise_after got %h/%h want 01/00", level_m, rise_m); end
        src_m = 8'h00;
        step(7);
        checks++;
        if (level_m !== 8'h01 || fall_m !== 8'h00) begin errors++; $display("FAIL fall_early got %h/%h want 01/00", level_m, fall_m); end
        step(1);
        checks++;
        if (level_m !== 8'h00 || fall_m !== 8'h01) begin errors++; $display("FAIL fall_edge got %h/%h want 00/01", level_m, fall_m); end
        step(4);
    endtask

    task automatic test_glitch();
        src_m = 8'h08;
        step(3);
        src_m = 8'h00;
        for (int k = 0; k < 12; k++) begin
            step(1);
            checks++;
            if (level_m !== 8'h00 || rise_m !== 8'h00 || fall_m !== 8'h00) begin
                errors++;
                $display("FAIL glitch_quiet cyc %0d got %h/%h/%h want 00/00/00", k, level_m, rise_m, fall_m);
            end
        end
`ifdef STOLEN_CDC_GLITCH_FLAG_EN
        checks++;
        if (gflag_m !== 8'h08) begin errors++; $display("FAIL glitch_flag_set got %h want 08", gflag_m); end
        gclr_m = 8'h08;
        step(1);
        gclr_m = 8'h00;
        checks++;
        if (gflag_m !== 8'h00) begin errors++; $display("FAIL glitch_flag_clr got %h want 00", gflag_m); end
`endif
    endtask

    // Exactly FILTER_CYCLES stable cycles is accepted; the return edge follows FILTER_CYCLES later.
    task automatic test_min_pulse();
        src_m = 8'h08;
        step(4);
        src_m = 8'h00;
        step(4);
        checks++;
        if (level_m !== 8'h08 || rise_m !== 8'h08) begin errors++; $display("FAIL minpulse_rise got %h/%h want 08/08", level_m, rise_m); end
        step(3);
        checks++;
        if (level_m !== 8'h08 || fall_m !== 8'h00) begin errors++; $display("FAIL minpulse_hold got %h/%h want 08/00", level_m, fall_m); end
        step(1);
        checks++;
        if (level_m !== 8'h00 || fall_m !== 8'h08) begin errors++; $display("FAIL minpulse_fall got %h/%h want 00/08", level_m, fall_m); end
        step(4);
    endtask

    task automatic test_multi();
        src_m = 8'hA5;
        step(7);
        checks++;
        if (level_m !== 8'h00 || rise_m !== 8'h00) begin errors++; $display("FAIL multi_early got %h/%h want 00/00", level_m, rise_m); end
        step(1);
        checks++;
        if (level_m !== 8'hA5 || rise_m !== 8'hA5 || fall_m !== 8'h00) begin errors++; $display("FAIL multi_rise got %h/%h/%h want a5/a5/00", level_m, rise_m, fall_m); end
        step(1);
        checks++;
        if (rise_m !== 8'h00) begin errors++; $display("FAIL multi_rise_single got %h want 00", rise_m); end
        src_m = 8'h00;
        step(8);
        checks++;
        if (level_m !== 8'h00 || fall_m !== 8'hA5 || rise_m !== 8'h00) begin errors++; $display("FAIL multi_fall got %h/%h/%h want 00/a5/00", level_m, fall_m, rise_m); end
        step(1);
        checks++;
        if (fall_m !== 8'h00) begin errors++; $display("FAIL multi_fall_single got %h want 00", fall_m); end
        step(2);
    endtask

    task automatic test_init_val();
        rst_i = 1'b0;
        step(1);
        checks++;
        if (level_i !== 8'hFF) begin errors++; $display("FAIL init_after_release got %h want ff", level_i); end
        step(6);
        checks++;
        if (level_i !== 8'hFF || fall_i !== 8'h00) begin errors++; $display("FAIL init_early got %h/%h want ff/00", level_i, fall_i); end
        step(1);
        checks++;
        if (level_i !== 8'h0F || fall_i !== 8'hF0 || rise_i !== 8'h00) begin errors++; $display("FAIL init_fall got %h/%h/%h want 0f/f0/00", level_i, fall_i, rise_i); end
    endtask

    task automatic test_reset_mid();
        src_m = 8'h02;
        step(6);
        rst_m = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            checks++;
            if (level_m !== 8'h00 || rise_m !== 8'h00 || fall_m !== 8'h00) begin
                errors++;
                $display("FAIL midrst_hold cyc %0d got %h/%h/%h want 00/00/00", k, level_m, rise_m, fall_m);
            end
        end
        rst_m = 1'b0;
        step(7);
        checks++;
        if (level_m !== 8'h00 || rise_m !== 8'h00) begin errors++; $display("FAIL midrst_early got %h/%h want 00/00", level_m, rise_m); end
        step(1);
        checks++;
        if (level_m !== 8'h02 || rise_m !== 8'h02) begin errors++; $display("FAIL midrst_rise got %h/%h want 02/02", level_m, rise_m); end
        src_m = 8'h00;
        step(8);
        checks++;
        if (level_m !== 8'h00 || fall_m !== 8'h02) begin errors++; $display("FAIL midrst_fall got %h/%h want 00/02", level_m, fall_m); end
    endtask

    task automatic test_fast_toggle();
        logic hist [0:20];
        logic exp_lvl;
        logic prev_lvl;
        for (int n = 0; n <= 20; n++) hist[n] = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            src_f = (((n - 1) / 2) % 2 == 0) ? 1'b1 : 1'b0;
            hist[n] = src_f[0];
            step(1);
            exp_lvl  = (n >= 3) ? hist[n-2] : 1'b0;
            prev_lvl = (n >= 4) ? hist[n-3] : 1'b0;
            checks++;
            if (level_f[0] !== exp_lvl || rise_f[0] !== (exp_lvl & ~prev_lvl) ||
                fall_f[0] !== (~exp_lvl & prev_lvl)) begin
                errors++;
                $display("FAIL fast_toggle edge %0d got %b/%b/%b want %b/%b/%b", n,
                         level_f[0], rise_f[0], fall_f[0],
                         exp_lvl, exp_lvl & ~prev_lvl, ~exp_lvl & prev_lvl);
            end
        end
    endtask

    initial begin
        rst_m = 1'b1;
        rst_i = 1'b1;
        rst_f = 1'b1;
        src_m = 8'h00;
        src_i = 8'h0F;
        src_f = 1'b0;
`ifdef STOLEN_CDC_GLITCH_FLAG_EN
        gclr_m = 8'h00;
        gclr_i = 8'h00;
        gclr_f = 1'b0;
`endif
        step(3);
        test_reset();
        rst_m = 1'b0;
        rst_f = 1'b0;
        step(8);
        test_single_rise();
        test_glitch();
        test_min_pulse();
        test_multi();
        test_init_val();
        test_reset_mid();
        test_fast_toggle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stolen_cdc_event_sync.md
STOLEN_CDC_EVENT_SYNC -- requirements
Module: stolen_cdc_event_sync

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of independent asynchronous channels (legal 1..64).
REQ-002 SHALL have parameter DEST_SYNC_FF, default 4, synchronizer depth per channel (legal 2..10).
REQ-003 SHALL have parameter FILTER_CYCLES, default 4, consecutive stable cycles required before a level change is accepted (legal 1..65535).
REQ-004 SHALL have parameter INIT_VAL, default all-zero (WIDTH bits), reset value of every synchronizer stage and of dest_level.
REQ-005 SHALL have port dest_clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port dest_rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port src_in  input  WIDTH  asynchronous channel inputs, no timing relationship to dest_clk.
REQ-008 SHALL have port dest_level  output  WIDTH  filtered, synchronized level per channel.
REQ-009 SHALL have port dest_rise  output  WIDTH  one-cycle pulse when dest_level bit goes 0->1.
REQ-010 SHALL have port dest_fall  output  WIDTH  one-cycle pulse when dest_level bit goes 1->0.
REQ-011 SHALL have ports glitch_clr  input  WIDTH  and glitch_flag  output  WIDTH, present only with STOLEN_CDC_GLITCH_FLAG_EN (REQ-024).

Function
REQ-012 SHALL sample src_in[i] into a DEST_SYNC_FF-deep shift chain per channel; sync_out[i] = last stage; stages carry ASYNC_REG and DONT_TOUCH, STOLEN_CDC = "EVENT_SYNC".
REQ-013 SHALL keep a per-channel counter cnt of width clog2(FILTER_CYCLES+1); while sync_out == dest_level, cnt <= 0.
REQ-014 SHALL, while sync_out != dest_level and cnt < FILTER_CYCLES-1, increment cnt.
REQ-015 SHALL, while sync_out != dest_level and cnt == FILTER_CYCLES-1, load dest_level <= sync_out and clear cnt in the same edge.
REQ-016 SHALL assert dest_rise/dest_fall registered, high exactly in the cycle dest_level shows the new value, low otherwise.
REQ-017 SHALL give latency from first dest_clk edge sampling a stable new src_in value to dest_level update of exactly DEST_SYNC_FF + FILTER_CYCLES - 1 further edges (FILTER_CYCLES=1: level tracks sync_out with one cycle delay).
REQ-018 SHALL treat a sync_out excursion shorter than FILTER_CYCLES cycles as a glitch: cnt returns to 0, dest_level and pulses unchanged.
REQ-019 SHALL process channels independently; simultaneous events on any channel subset produce simultaneous per-bit pulses.
REQ-020 SHALL never assert dest_rise and dest_fall on the same bit in the same cycle; minimum spacing between pulses on one bit is FILTER_CYCLES cycles.

Reset
REQ-021 SHALL, while dest_rst=1, load all sync stages and dest_level with INIT_VAL, cnt with 0, dest_rise/dest_fall with 0 (glitch_flag 0 if present).
REQ-022 SHALL, on dest_rst asserted mid-filter, discard the pending count; after release a src_in differing from INIT_VAL produces a normal edge pulse after REQ-017 latency counted from the first post-reset edge.

Configuration
REQ-023 SHALL use macro STOLEN_CDC_GLITCH_FLAG_EN.
REQ-024 SHALL, with the macro defined, set glitch_flag[i] sticky when REQ-018 fires on channel i (cnt nonzero and sync_out returns to dest_level); glitch_clr[i] clears it; set wins over simultaneous clear; without the macro, the ports, flags and logic are absent and REQ-012..022 are unchanged.

Structure
REQ-025 SHALL place clog2 function, parameter range limits and the STOLEN_CDC attribute string constant in shared package stolen_cdc_pkg.
REQ-026 SHALL implement one channel (sync chain, filter counter, edge pulses, optional flag) as sub-module stolen_cdc_filter_bit, instantiated WIDTH times in a generate loop; top module remains KEEP_HIERARCHY.
REQ-027 SHALL elaborate-time error on any parameter outside REQ-001..004 ranges.

Verification
REQ-028 SHALL cover: WIDTH=8, DEST_SYNC_FF=4, FILTER_CYCLES=4, src_in[0] 0->1 held -> dest_level[0]=1 and dest_rise[0] one cycle, 7 edges after first sampling edge.
REQ-029 SHALL cover: src_in[3] high for 3 dest_clk cycles then low (FILTER_CYCLES=4) -> no dest_level change, no pulses; glitch_flag[3]=1 with macro, cleared by one-cycle glitch_clr[3].
REQ-030 SHALL cover: src_in 0x00->0xA5 in one cycle -> dest_rise=0xA5 single cycle, then 0xA5->0x00 -> dest_fall=0xA5 single cycle.
REQ-031 SHALL cover: INIT_VAL=0xFF, src_in=0x0F held through reset -> after release dest_level=0xFF, then dest_fall=0xF0 after REQ-017 latency.
REQ-032 SHALL cover: dest_rst pulsed while cnt=2 on channel 1 -> cnt=0, dest_level=INIT_VAL, no pulse during reset.
REQ-033 SHALL cover: FILTER_CYCLES=1, DEST_SYNC_FF=2, src_in[0] toggling every 2 cycles -> dest_level[0] follows with 2-edge latency, alternating rise/fall pulses.
